// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Number of CHUNK-bit carry stages needed to cover WIDTH bits.
  function automatic int nstages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/addsub_chunk_stage.sv
// One CHUNK-bit slice of the carry chain. It registers the chunk sum and the
// carry out, and carries the operation's valid/sub/sign bits along with it.
// With PIPELINE_ENABLE = 0 it collapses to pure combinational logic.
module addsub_chunk_stage #(
  parameter int CHUNK           = 4,
  parameter bit PIPELINE_ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             valid,
  input  logic             sub,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic             carry,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             valid_s,
  output logic             sub_s,
  output logic             sign_a_s,
  output logic             sign_b_s,
  output logic             carry_s,
  output logic [CHUNK-1:0] sum
);

  // b is already inverted for subtract and carry is already the effective carry.
  logic [CHUNK:0] total;
  assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, carry};

  if (PIPELINE_ENABLE) begin : g_reg
    // Stage register: chunk result plus the side-band bits of the same operation.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_s  <= 1'b0;
        sub_s    <= 1'b0;
        sign_a_s <= 1'b0;
        sign_b_s <= 1'b0;
        carry_s  <= 1'b0;
        sum      <= '0;
      end else if (ce) begin
        valid_s          <= valid;
        sub_s            <= sub;
        sign_a_s         <= sign_a;
        sign_b_s         <= sign_b;
        {carry_s, sum}   <= total;
      end
    end
  end else begin : g_comb
    assign valid_s        = valid;
    assign sub_s          = sub;
    assign sign_a_s       = sign_a;
    assign sign_b_s       = sign_b;
    assign {carry_s, sum} = total;
  end

endmodule

// File: rtl/nbit_pipelined_addsub.sv
// WIDTH-bit adder/subtractor with the carry chain cut into CHUNK-bit stages.
// Operand chunk j is skewed j stages so it meets the carry from below; result
// chunk j is de-skewed NSTAGES-1-j stages so all chunks leave together.
module nbit_pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int CHUNK           = 4,
  parameter bit PIPELINE_ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             valid_out,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTAGES = nstages(WIDTH, CHUNK);

  if (WIDTH % CHUNK != 0 || NSTAGES < 1) begin : g_bad_cfg
    $error("nbit_pipelined_addsub: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
           WIDTH, CHUNK);
  end

  // Subtract is a + ~b + ~cin, so invert b and the carry-in up front.
  logic [WIDTH-1:0] b_eff;
  assign b_eff = (sub == MODE_SUB) ? ~b : b;

  // Index k is the value entering stage k; index NSTAGES leaves the last stage.
  logic [NSTAGES:0] vld_pipe, carry, sub_pipe, sign_a_pipe, sign_b_pipe;
  assign vld_pipe[0]    = valid_in;
  assign carry[0]       = (sub == MODE_SUB) ? ~cin : cin;
  assign sub_pipe[0]    = sub;
  assign sign_a_pipe[0] = a[WIDTH-1];
  assign sign_b_pipe[0] = b[WIDTH-1];

  for (genvar j = 0; j < NSTAGES; j++) begin : g_chunk
    localparam int SKEW   = j;
    localparam int DESKEW = NSTAGES - 1 - j;

    logic [CHUNK-1:0] a_at, b_at, chunk_sum;

    if (PIPELINE_ENABLE && SKEW > 0) begin : g_skew
      logic [SKEW-1:0][CHUNK-1:0] a_q, b_q;
      // Operand chunk waits SKEW stages for the carry of the chunks below it.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ce) begin
          for (int i = SKEW - 1; i > 0; i--) begin
            a_q[i] <= a_q[i-1];
            b_q[i] <= b_q[i-1];
          end
          a_q[0] <= a[j*CHUNK +: CHUNK];
          b_q[0] <= b_eff[j*CHUNK +: CHUNK];
        end
      end
      assign a_at = a_q[SKEW-1];
      assign b_at = b_q[SKEW-1];
    end else begin : g_no_skew
      assign a_at = a[j*CHUNK +: CHUNK];
      assign b_at = b_eff[j*CHUNK +: CHUNK];
    end

    addsub_chunk_stage #(
      .CHUNK           (CHUNK),
      .PIPELINE_ENABLE (PIPELINE_ENABLE)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .valid    (vld_pipe[j]),
      .sub      (sub_pipe[j]),
      .sign_a   (sign_a_pipe[j]),
      .sign_b   (sign_b_pipe[j]),
      .carry    (carry[j]),
      .a        (a_at),
      .b        (b_at),
      .valid_s  (vld_pipe[j+1]),
      .sub_s    (sub_pipe[j+1]),
      .sign_a_s (sign_a_pipe[j+1]),
      .sign_b_s (sign_b_pipe[j+1]),
      .carry_s  (carry[j+1]),
      .sum      (chunk_sum)
    );

    if (PIPELINE_ENABLE && DESKEW > 0) begin : g_deskew
      logic [DESKEW-1:0][CHUNK-1:0] s_q;
      // Finished result chunk waits for the upper chunks of the same operation.
      always_ff @(posedge clk) begin
        if (rst) begin
          s_q <= '0;
        end else if (ce) begin
          for (int i = DESKEW - 1; i > 0; i--) s_q[i] <= s_q[i-1];
          s_q[0] <= chunk_sum;
        end
      end
      assign sum[j*CHUNK +: CHUNK] = s_q[DESKEW-1];
    end else begin : g_no_deskew
      assign sum[j*CHUNK +: CHUNK] = chunk_sum;
    end
  end

  assign valid_out = vld_pipe[NSTAGES];
  assign cout      = carry[NSTAGES];

  // Signed overflow: operand signs agree (add) or differ (sub), and the
  // result sign departs from a. Uses the sub/sign bits carried with this op.
  logic signs_match;
  assign signs_match = (sub_pipe[NSTAGES] == MODE_SUB)
                     ? (sign_a_pipe[NSTAGES] != sign_b_pipe[NSTAGES])
                     : (sign_a_pipe[NSTAGES] == sign_b_pipe[NSTAGES]);
  assign ovf = signs_match && (sum[WIDTH-1] != sign_a_pipe[NSTAGES]);

endmodule

// File: doc/nbit_pipelined_addsub.md
# nbit_pipelined_addsub

Parameterised N-bit adder/subtractor. The carry chain is split into CHUNK-bit pipeline stages, so throughput is one operation per clock at any WIDTH. This is the next generation of the team's N-bit full/half adder. It adds:
- a per-operation add/subtract mode,
- a valid qualifier and a clock-enable stall,
- a signed-overflow flag,
- a combinational bypass mode.

It sits on datapaths where WIDTH is too wide to close timing in a single ripple-carry cycle.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per pipeline stage; NSTAGES = WIDTH/CHUNK.
- PIPELINE_ENABLE, 1, 1 = registered stages; 0 = fully combinational path.
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  clock enable; 0 freezes every pipeline register.
- valid_in  input  1  a, b, cin, sub are meaningful this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in when adding; borrow-in when subtracting.
- sub  input  1  0 = add, 1 = subtract.
- valid_out  output  1  sum, cout, ovf correspond to a completed operation.
- sum  output  WIDTH  result modulo 2^WIDTH.
- cout  output  1  raw carry out of the MSB stage.
- ovf  output  1  two's-complement signed overflow.

## Operation
- Add: {cout,sum} = a + b + cin.
- Sub: {cout,sum} = a + ~b + ~cin, which equals a − b − cin mod 2^WIDTH.
  - cout = 1 means no borrow; cout = 0 means a borrow occurred.
- ovf rules, with sign bits at WIDTH−1:
  - Add: sign(a) == sign(b) and sign(sum) != sign(a).
  - Sub: sign(a) != sign(b) and sign(sum) != sign(a).
- Stage k (k = 0..NSTAGES−1) adds chunk k of a and effective b, plus the carry registered from stage k−1. Stage 0 uses the effective carry-in.
- Operand chunks not yet consumed travel forward through skew registers. Result chunks already produced travel forward through de-skew registers. All chunks of one operation therefore emerge together.
- The sub bit and the operand sign bits travel with the operation so ovf is computed in the final stage.
- valid travels through a NSTAGES-deep shift register alongside the data.
- Data registers may be updated when valid is 0. Outputs are defined only while valid_out is 1, except after reset.
- ce = 0: every register holds, including valid. Inputs presented that cycle are ignored, and outputs hold their values.
- PIPELINE_ENABLE = 0: no registers. Outputs are a pure function of the current inputs, valid_out = valid_in, and ce and rst have no effect.

## Timing
- PIPELINE_ENABLE = 1: latency is exactly NSTAGES ce-qualified rising edges from the sampling edge to valid_out. Throughput is 1 operation per ce cycle.
- Reset values: valid_out = 0, sum = 0, cout = 0, ovf = 0, and all internal stage registers = 0.
- rst has priority over ce. When rst is high on an edge, the pipeline clears regardless of ce.
- Reset mid-operation discards every in-flight operation; none produces valid_out. An operation sampled on the first edge after rst deasserts completes normally.
- Back-to-back operations with alternating sub values must not interfere, because each stage uses the sub bit carried with its own operation.
- NSTAGES = 1 degenerates to a single registered adder with latency 1.

## Structure
- Shared package `addsub_pkg`:
  - constants `MODE_ADD = 1'b0` and `MODE_SUB = 1'b1`;
  - function `nstages(width, chunk)`.
- Sub-module `addsub_chunk_stage` provides one CHUNK-bit adder with registered sum chunk and carry, plus the valid/sub/sign pass-through. It has a combinational bypass when PIPELINE_ENABLE = 0.
- The top level generates NSTAGES instances and the skew/de-skew register triangles.
- Elaboration error if WIDTH % CHUNK != 0.

## Test plan
All scenarios use WIDTH = 8 and CHUNK = 4 (NSTAGES = 2) unless stated.
- Reset: rst = 1 for 3 cycles with random inputs and valid_in = 1 → valid_out = 0, sum = 0, cout = 0, ovf = 0 on every cycle.
- Add with carry: a = 200, b = 100, cin = 0, sub = 0 → after 2 edges valid_out = 1, sum = 44, cout = 1, ovf = 0. Then a = 0x7F, b = 0x01 → sum = 0x80, cout = 0, ovf = 1.
- Subtract with borrow: a = 5, b = 7, cin = 0, sub = 1 → sum = 0xFE, cout = 0, ovf = 0. Then a = 0x80, b = 0x01, sub = 1 → sum = 0x7F, cout = 1, ovf = 1.
- Streaming and stall:
  - 50 random back-to-back operations with mixed sub → each result matches the reference model exactly 2 cycles later.
  - Hold ce = 0 for 3 cycles mid-stream → outputs frozen, and no operation is lost or duplicated.
- Reset mid-flight: assert rst for 1 cycle with 2 operations in flight → neither emerges, and the next operation completes with 2-cycle latency.
- Parameter sweep: WIDTH = 32 / CHUNK = 8 and PIPELINE_ENABLE = 0 with 50 random vectors each → latency 4 and 0 respectively, all results correct.
